// File: rtl/dino_pkg.sv
// dino_pkg
// Shared encodings for the dinosaur game: game-state codes driven on the
// sequencer's state output, obstacle codes for the next Map1 content,
// seven-segment glyphs used by the display datapath, and a helper that keeps
// obstacle codes within the legal 0..2 range.
// No ports (package).

package dino_pkg;

    typedef logic [2:0] state_t;

    // Game-state codes as seen by the display datapath
    localparam state_t RST_S = 3'd0;
    localparam state_t RUN   = 3'd1;
    localparam state_t PAUSE = 3'd2;
    localparam state_t WIN   = 3'd3;
    localparam state_t LOSE  = 3'd4;

    // Obstacle codes for the next Map1 cell
    localparam logic [1:0] OBS_BARRIER = 2'd0;
    localparam logic [1:0] OBS_GROUND  = 2'd1;
    localparam logic [1:0] OBS_BIRD    = 2'd2;

    // Seven-segment glyphs, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK   = 7'b000_0000;
    localparam logic [6:0] SEG_GROUND  = 7'b000_1000;
    localparam logic [6:0] SEG_BARRIER = 7'b011_0000;
    localparam logic [6:0] SEG_BIRD    = 7'b010_0011;
    localparam logic [6:0] SEG_DINO    = 7'b101_1100;
    localparam logic [6:0] SEG_P       = 7'b111_0011;
    localparam logic [6:0] SEG_W       = 7'b011_1110;
    localparam logic [6:0] SEG_L       = 7'b011_1000;

    // Code 3 has no obstacle meaning; it is shown as plain ground
    function automatic logic [1:0] fold_obst(input logic [1:0] raw);
        return (raw == 2'd3) ? OBS_GROUND : raw;
    endfunction

endpackage

// File: rtl/dino_obst_gen.sv
// dino_obst_gen
// Candidate generator for the next Map1 obstacle. The sequencer registers the
// candidate onto its obst_sel output at each map shift.
// Configuration macro: DINO_LFSR_EN
//   defined   : 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5), stepped on
//               every cycle where adv=1; candidate is lfsr[1:0] with 3 -> ground.
//   undefined : mod-3 counter 0,1,2,0,... stepped on every cycle where adv=1.
// Ports:
//   clk      in  1  system clock
//   Reset    in  1  synchronous active-low reset
//   adv      in  1  advance the generator this cycle
//   obst_sel out 2  current candidate obstacle code (0..2)

module dino_obst_gen
    import dino_pkg::*;
(
    input  logic       clk,
    input  logic       Reset,
    input  logic       adv,
    output logic [1:0] obst_sel
);

`ifdef DINO_LFSR_EN
    logic [7:0] lfsr;

    // Shift left, feeding back x^8+x^6+x^5+x^4 into bit 0
    always_ff @(posedge clk) begin
        if (!Reset) begin
            lfsr <= 8'hA5;
        end else if (adv) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign obst_sel = fold_obst(lfsr[1:0]);
`else
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            cnt <= OBS_BARRIER;
        end else if (adv) begin
            cnt <= (cnt == OBS_BIRD) ? OBS_BARRIER : cnt + 2'd1;
        end
    end

    assign obst_sel = cnt;
`endif

endmodule

// File: rtl/dino_game_sequencer.sv
// dino_game_sequencer
// Single-clock scheduler for the dinosaur game. A prescaler produces the map
// scroll pulse, a step counter fills the level thermometer, qualified hits
// drain the lives thermometer, and a small FSM tracks RUN/PAUSE/WIN/LOSE.
// Configuration macro: DINO_LFSR_EN selects the LFSR obstacle source in
// dino_obst_gen (undefined: mod-3 rotation).
// Ports:
//   clk      in  1  system clock, the only clock
//   Reset    in  1  synchronous active-low reset
//   Stop     in  1  pause request (level)
//   Hard     in  1  difficulty: 1 selects TICK_HARD period
//   hit      in  1  collision flag, only meaningful while shift_en=1
//   shift_en out 1  one-cycle map shift pulse
//   obst_sel out 2  next Map1 content, valid with shift_en
//   level    out 3  progress thermometer 000/100/110/111
//   lives    out 2  remaining-lives thermometer 11/01/00
//   state    out 3  game-state code (dino_pkg)
//   win      out 1  sticky win flag
//   lose     out 1  sticky lose flag

module dino_game_sequencer
    import dino_pkg::*;
#(
    parameter int TICK_EASY       = 12_500_000,
    parameter int TICK_HARD       = 6_250_000,
    parameter int STEPS_PER_LEVEL = 10,
    parameter int LIVES           = 2
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Stop,
    input  logic       Hard,
    input  logic       hit,
    output logic       shift_en,
    output logic [1:0] obst_sel,
    output logic [2:0] level,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       win,
    output logic       lose
);

    localparam int PW = $clog2(TICK_EASY + 1);
    localparam int SW = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;

    localparam logic [PW-1:0] LAST_EASY  = PW'(TICK_EASY - 1);
    localparam logic [PW-1:0] LAST_HARD  = PW'(TICK_HARD - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEPS_PER_LEVEL - 1);
    localparam logic [1:0]    LIVES_INIT = (LIVES >= 2) ? 2'b11 : 2'b01;

    logic [PW-1:0] presc;
    logic [PW-1:0] tick_last;
    logic [SW-1:0] step;
    logic          running;
    logic          wrap;
    logic          gen_adv;
    logic [1:0]    obst_next;
    logic [2:0]    level_next;
    logic [1:0]    lives_next;
    logic          step_wrap;
    logic          final_hit;
    logic          final_level;
    state_t        next_state;

    assign running = (state == RUN);
    assign wrap    = running && (presc == tick_last);

    // The LFSR free-runs through RUN so obstacle choice depends on elapsed
    // time; the counter variant only moves when a shift is issued.
`ifdef DINO_LFSR_EN
    assign gen_adv = running;
`else
    assign gen_adv = wrap;
`endif

    dino_obst_gen u_obst_gen (
        .clk      (clk),
        .Reset    (Reset),
        .adv      (gen_adv),
        .obst_sel (obst_next)
    );

    // Consequences of the shift being processed this cycle. A hit clears the
    // most significant set bit of lives; a level step fills from the MSB.
    always_comb begin
        level_next  = {1'b1, level[2:1]};
        lives_next  = lives[1] ? {1'b0, lives[0]} : 2'b00;
        step_wrap   = (step == STEP_LAST);
        final_hit   = shift_en && hit && (lives_next == 2'b00);
        final_level = shift_en && step_wrap && (level_next == 3'b111);
    end

    // Game FSM. A losing hit outranks a simultaneous winning step, and both
    // outrank the pause request so an end condition is never missed.
    always_comb begin
        next_state = state;
        case (state)
            RST_S:   next_state = RUN;
            RUN:     next_state = Stop ? PAUSE : RUN;
            PAUSE:   next_state = Stop ? PAUSE : RUN;
            WIN:     next_state = WIN;
            LOSE:    next_state = LOSE;
            default: next_state = RST_S;
        endcase
        if (state == RUN || state == PAUSE) begin
            if (final_hit) begin
                next_state = LOSE;
            end else if (final_level) begin
                next_state = WIN;
            end
        end
    end

    // Prescaler, step/level/lives bookkeeping and output registers. The tick
    // length is latched only at a wrap so a Hard change never truncates or
    // stretches the period already in progress.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state     <= RST_S;
            presc     <= '0;
            tick_last <= Hard ? LAST_HARD : LAST_EASY;
            step      <= '0;
            shift_en  <= 1'b0;
            obst_sel  <= OBS_GROUND;
            level     <= 3'b000;
            lives     <= LIVES_INIT;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else begin
            state    <= next_state;
            shift_en <= wrap;

            if (state == RST_S) begin
                tick_last <= Hard ? LAST_HARD : LAST_EASY;
            end

            if (running) begin
                if (wrap) begin
                    presc     <= '0;
                    tick_last <= Hard ? LAST_HARD : LAST_EASY;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            if (wrap) begin
                obst_sel <= obst_next;
            end

            if (shift_en) begin
                if (step_wrap) begin
                    step  <= '0;
                    level <= level_next;
                end else begin
                    step <= step + SW'(1);
                end
                if (hit) begin
                    lives <= lives_next;
                end
            end

            if (next_state == WIN) begin
                win <= 1'b1;
            end
            if (next_state == LOSE) begin
                lose <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dino_game_sequencer.md
# dino_game_sequencer

Central sequencer for the little-dinosaur game. It generates the scroll tick that shifts the four-digit map and picks the next obstacle. It tracks progress and lives, and drives the RUN/PAUSE/WIN/LOSE game state that the display datapath uses to select the end screens. It sits between the board inputs (clk, Reset, Stop, Hard) and the map/role datapath, replacing ripple-clocked tick logic with a single-clock scheduler.

## Interface
Parameters:
- TICK_EASY, 12_500_000: clk cycles per map shift when Hard=0.
- TICK_HARD, 6_250_000: clk cycles per map shift when Hard=1.
- STEPS_PER_LEVEL, 10: shifts per progress level.
- LIVES, 2: collisions tolerated before LOSE (legal range 1..2).

Ports:
- clk  in  1  system clock; the only clock.
- Reset  in  1  reset, synchronous, active-low.
- Stop  in  1  pause request (level); freezes all counters.
- Hard  in  1  difficulty select.
- hit  in  1  collision flag from datapath; sampled only in cycles where shift_en=1.
- shift_en  out  1  one-cycle pulse; the datapath shifts Map1→Map2→Map3 on it.
- obst_sel  out  2  next Map1 content, valid with shift_en: 0=barrier, 1=ground, 2=bird; never 3.
- level  out  3  progress thermometer: 000→100→110→111.
- lives  out  2  thermometer of remaining lives: 11, 01, 00.
- state  out  3  game-state code from the package.
- win, lose  out  1  sticky end flags.

## Operation
- States: RST_S, RUN, PAUSE, WIN, LOSE.
- RST_S→RUN after exactly one cycle.
- RUN→PAUSE when Stop=1; PAUSE→RUN when Stop=0.
- RUN→LOSE on a qualified hit that consumes the last life.
- RUN→WIN when level reaches 111.
- WIN and LOSE are absorbing; only Reset leaves them.
- Prescaler: counts 0..T-1 in RUN only, where T=Hard?TICK_HARD:TICK_EASY. On reaching T-1 it wraps to 0 and issues shift_en the next cycle.
  - T is re-evaluated only at wrap, so a Hard change mid-period takes effect from the next period.
  - Width is $clog2(TICK_EASY+1); assume TICK_HARD ≤ TICK_EASY.
- Step counter: increments on each shift_en. At STEPS_PER_LEVEL-1 it wraps to 0 and shifts a 1 into level from the MSB side.
- Hit: qualified only when hit=1 in the same cycle as shift_en. It clears the MSB-most set bit of lives.
  - If lives becomes 00, the FSM moves to LOSE next cycle.
- Simultaneous final hit and final level step: LOSE wins; level still updates.
- PAUSE: prescaler, step counter, obst_sel and lives hold. shift_en=0.
- WIN/LOSE: shift_en=0 and counters frozen; win or lose is held at 1.
- Reset asserted in any state, including mid-period: all state returns to reset values on the next edge.
- Reset values: shift_en=0, obst_sel=1 (ground), level=000, lives=11 (LIVES=2) or 01 (LIVES=1), state=RST_S, win=0, lose=0, prescaler=0, step=0.

## Timing
- First shift_en occurs T+1 cycles after Reset deasserts: 1 cycle in RST_S, then T prescaler counts.
- Thereafter shift_en recurs every T cycles in RUN; cycles spent in PAUSE extend the period exactly by their count.
- obst_sel updates in the same cycle as shift_en (registered) and holds between pulses.
- level, lives, win and lose update one cycle after the qualifying shift_en.
- state reaches WIN/LOSE in that same cycle.
- No combinational paths from inputs to outputs.

## Configuration
- DINO_LFSR_EN defined: obst_sel comes from an 8-bit Fibonacci LFSR with taps 8,6,5,4 and seed 8'hA5, advanced every clk cycle in RUN.
  - obst_sel = lfsr[1:0], with the value 3 folded to 1 (ground).
- DINO_LFSR_EN undefined: obst_sel comes from a mod-3 counter (0,1,2,0,…) advanced on every shift_en, starting from 0 after reset.

## Structure
- Package dino_pkg: state encoding constants (RST_S=0, RUN=1, PAUSE=2, WIN=3, LOSE=4), obstacle codes (OBS_BARRIER=0, OBS_GROUND=1, OBS_BIRD=2), and the 7-segment glyph constants shared with the display datapath.
- Sub-module dino_obst_gen: contains the LFSR/mod-3 selector under DINO_LFSR_EN. Ports: clk, Reset, adv, obst_sel.
- All prescaler, step, lives and FSM logic stays in the top module.

## Test plan
All scenarios use overrides TICK_EASY=4, TICK_HARD=2, STEPS_PER_LEVEL=3, LIVES=2.
- Reset release with Hard=0, hit=0 → state RST_S then RUN; first shift_en at cycle 5; then shift_en every 4 cycles; obst_sel cycles 0,1,2 (macro off).
- Run 9 shifts with no hits → level goes 100, 110, 111 after shifts 3/6/9; state=WIN and win=1 one cycle after shift 9; no further shift_en.
- Assert hit on shift 1 and shift 2 → lives 11→01→00; lose=1 and state=LOSE one cycle after shift 2.
- Hold Stop=1 for 7 cycles mid-period → state=PAUSE, no shift_en, counters held; next shift_en arrives exactly 7 cycles late.
- Toggle Hard 0→1 two cycles into a period → the current period stays 4 cycles; subsequent periods are 2 cycles.
- Assert Reset for one cycle during LOSE, and again mid-period in RUN → all outputs return to reset values the next cycle; the sequence restarts with first shift_en 5 cycles after release.
